// File: rtl/peak_column_scheduler.sv
// peak_column_scheduler
// Reduces two 12-bit sample streams to one peak per window of window_len
// samples per channel and writes both column buffers in the same cycle once
// both channels have completed their window. A freeze input discards
// completed windows instead of emitting them.
//
// Optional build macro: PEAK_DECAY_EN
//   When defined, each emitted column is max(window peak, previous emitted
//   column - DECAY_STEP), clamped at 0, giving a falling-peak display.
//   When undefined, the column is simply the window peak.
module peak_column_scheduler #(
    parameter int DATA_W     = 12,
    parameter int LEN_W      = 16,
    parameter int DECAY_STEP = 16
) (
    input  logic              data_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample_a,
    input  logic              sample_valid_a,
    input  logic [DATA_W-1:0] sample_b,
    input  logic              sample_valid_b,
    input  logic [LEN_W-1:0]  window_len,
    input  logic              freeze,
    output logic [DATA_W-1:0] sink_data_a,
    output logic [DATA_W-1:0] sink_data_b,
    output logic              sink_valid_a,
    output logic              sink_valid_b,
    output logic [LEN_W-1:0]  column_count,
    output logic              column_dropped
);

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_EMIT  = 1'b1
    } state_t;

    // Unsigned peak of two samples.
    function automatic logic [DATA_W-1:0] f_umax(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
        return (x > y) ? x : y;
    endfunction

    // Previous column minus the decay step, clamped at zero.
    function automatic logic [DATA_W-1:0] f_sat_sub(input logic [DATA_W-1:0] x);
        int unsigned xu;
        int unsigned step;
        xu   = 32'(x);
        step = DECAY_STEP;
        return (xu > step) ? DATA_W'(xu - step) : '0;
    endfunction

    state_t            r_state;
    logic [LEN_W-1:0]  r_len_q;
    logic [LEN_W-1:0]  r_cnt_a;
    logic [LEN_W-1:0]  r_cnt_b;
    logic [DATA_W-1:0] r_max_a;
    logic [DATA_W-1:0] r_max_b;
    logic [DATA_W-1:0] r_sink_a;
    logic [DATA_W-1:0] r_sink_b;
    logic              r_vld;
    logic              r_drop;
    logic [LEN_W-1:0]  r_count;

    logic              w_done;
    logic [LEN_W-1:0]  w_len_eff;
    logic [DATA_W-1:0] w_col_a;
    logic [DATA_W-1:0] w_col_b;

    // A window length of zero behaves as a single-sample window.
    assign w_len_eff = (window_len == '0) ? LEN_ONE : window_len;

    // Both channels have reached the latched window length.
    assign w_done = (r_cnt_a == r_len_q) && (r_cnt_b == r_len_q);

`ifdef PEAK_DECAY_EN
    logic [DATA_W-1:0] r_last_a;
    logic [DATA_W-1:0] r_last_b;

    assign w_col_a = f_umax(r_max_a, f_sat_sub(r_last_a));
    assign w_col_b = f_umax(r_max_b, f_sat_sub(r_last_b));

    // Track the last emitted column per channel; dropped windows leave it alone.
    always_ff @(posedge data_clk) begin
        if (reset) begin
            r_last_a <= '0;
            r_last_b <= '0;
        end else if ((r_state == ST_EMIT) && !freeze) begin
            r_last_a <= w_col_a;
            r_last_b <= w_col_b;
        end
    end
`else
    assign w_col_a = r_max_a;
    assign w_col_b = r_max_b;
`endif

    // Window accumulation, emit/drop sequencing and registered outputs.
    always_ff @(posedge data_clk) begin
        if (reset) begin
            r_state  <= ST_ACCUM;
            r_len_q  <= w_len_eff;
            r_cnt_a  <= '0;
            r_cnt_b  <= '0;
            r_max_a  <= '0;
            r_max_b  <= '0;
            r_sink_a <= '0;
            r_sink_b <= '0;
            r_vld    <= 1'b0;
            r_drop   <= 1'b0;
            r_count  <= '0;
        end else begin
            r_vld  <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                ST_ACCUM: begin
                    // A channel that already holds a full window keeps folding
                    // samples into its peak while waiting for the other one.
                    if (sample_valid_a) begin
                        r_max_a <= f_umax(r_max_a, sample_a);
                        if (r_cnt_a < r_len_q) begin
                            r_cnt_a <= r_cnt_a + LEN_ONE;
                        end
                    end
                    if (sample_valid_b) begin
                        r_max_b <= f_umax(r_max_b, sample_b);
                        if (r_cnt_b < r_len_q) begin
                            r_cnt_b <= r_cnt_b + LEN_ONE;
                        end
                    end
                    if (w_done) begin
                        r_state <= ST_EMIT;
                        r_len_q <= w_len_eff;
                    end
                end
                ST_EMIT: begin
                    if (!freeze) begin
                        r_vld    <= 1'b1;
                        r_sink_a <= w_col_a;
                        r_sink_b <= w_col_b;
                        r_count  <= r_count + LEN_ONE;
                    end else begin
                        r_drop <= 1'b1;
                    end
                    // A sample arriving now opens the next window.
                    r_max_a <= sample_valid_a ? sample_a : '0;
                    r_cnt_a <= sample_valid_a ? LEN_ONE : '0;
                    r_max_b <= sample_valid_b ? sample_b : '0;
                    r_cnt_b <= sample_valid_b ? LEN_ONE : '0;
                    r_state <= ST_ACCUM;
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

    assign sink_data_a    = r_sink_a;
    assign sink_data_b    = r_sink_b;
    assign sink_valid_a   = r_vld;
    assign sink_valid_b   = r_vld;
    assign column_count   = r_count;
    assign column_dropped = r_drop;

endmodule

// File: tb/tb_peak_column_scheduler.sv
// Directed bench for peak_column_scheduler. Each table row gives the inputs
// applied before one rising edge and the outputs expected just after it.
module tb_peak_column_scheduler;

    localparam int DATA_W = 12;
    localparam int LEN_W  = 16;
    localparam int TMAX   = 16;

    logic              data_clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] sample_a;
    logic              sample_valid_a;
    logic [DATA_W-1:0] sample_b;
    logic              sample_valid_b;
    logic [LEN_W-1:0]  window_len;
    logic              freeze;
    logic [DATA_W-1:0] sink_data_a;
    logic [DATA_W-1:0] sink_data_b;
    logic              sink_valid_a;
    logic              sink_valid_b;
    logic [LEN_W-1:0]  column_count;
    logic              column_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    logic        t_va [TMAX];
    int unsigned t_a  [TMAX];
    logic        t_vb [TMAX];
    int unsigned t_b  [TMAX];
    logic        t_fz [TMAX];
    logic        t_ev [TMAX];
    int unsigned t_ea [TMAX];
    int unsigned t_eb [TMAX];
    logic        t_ed [TMAX];
    int          t_n = 0;

    always #5 data_clk = ~data_clk;

    peak_column_scheduler #(
        .DATA_W    (DATA_W),
        .LEN_W     (LEN_W),
        .DECAY_STEP(16)
    ) dut (
        .data_clk      (data_clk),
        .reset         (reset),
        .sample_a      (sample_a),
        .sample_valid_a(sample_valid_a),
        .sample_b      (sample_b),
        .sample_valid_b(sample_valid_b),
        .window_len    (window_len),
        .freeze        (freeze),
        .sink_data_a   (sink_data_a),
        .sink_data_b   (sink_data_b),
        .sink_valid_a  (sink_valid_a),
        .sink_valid_b  (sink_valid_b),
        .column_count  (column_count),
        .column_dropped(column_dropped)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge data_clk);
        #1;
    endtask

    task automatic drive_idle();
        sample_valid_a = 1'b0;
        sample_a       = '0;
        sample_valid_b = 1'b0;
        sample_b       = '0;
        freeze         = 1'b0;
    endtask

    task automatic do_reset(input int unsigned len);
        drive_idle();
        window_len = LEN_W'(len);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic add(input logic va, input int unsigned a, input logic vb, input int unsigned b,
                       input logic fz, input logic ev, input int unsigned ea, input int unsigned eb,
                       input logic ed);
        t_va[t_n] = va; t_a[t_n] = a; t_vb[t_n] = vb; t_b[t_n] = b; t_fz[t_n] = fz;
        t_ev[t_n] = ev; t_ea[t_n] = ea; t_eb[t_n] = eb; t_ed[t_n] = ed;
        t_n++;
    endtask

    // Idle row with no strobe expected.
    task automatic add_idle(input logic fz);
        add(1'b0, 0, 1'b0, 0, fz, 1'b0, 0, 0, 1'b0);
    endtask

    // Idle row after which a column strobe with the given values is expected.
    task automatic add_emit(input int unsigned ea, input int unsigned eb);
        add(1'b0, 0, 1'b0, 0, 1'b0, 1'b1, ea, eb, 1'b0);
    endtask

    task automatic run_tab(input string name);
        for (int i = 0; i < t_n; i++) begin
            sample_valid_a = t_va[i];
            sample_a       = DATA_W'(t_a[i]);
            sample_valid_b = t_vb[i];
            sample_b       = DATA_W'(t_b[i]);
            freeze         = t_fz[i];
            tick();
            check_eq($sformatf("%s[%0d].valid_a", name, i), 32'(sink_valid_a), 32'(t_ev[i]));
            check_eq($sformatf("%s[%0d].valid_b", name, i), 32'(sink_valid_b), 32'(t_ev[i]));
            check_eq($sformatf("%s[%0d].dropped", name, i), 32'(column_dropped), 32'(t_ed[i]));
            if (t_ev[i]) begin
                check_eq($sformatf("%s[%0d].data_a", name, i), 32'(sink_data_a), t_ea[i]);
                check_eq($sformatf("%s[%0d].data_b", name, i), 32'(sink_data_b), t_eb[i]);
            end
        end
        drive_idle();
        t_n = 0;
    endtask

    initial begin
        reset      = 1'b1;
        window_len = LEN_W'(4);
        drive_idle();

        // Reset state
        do_reset(4);
        check_eq("rst.valid_a", 32'(sink_valid_a), 0);
        check_eq("rst.valid_b", 32'(sink_valid_b), 0);
        check_eq("rst.dropped", 32'(column_dropped), 0);
        check_eq("rst.count", 32'(column_count), 0);
        check_eq("rst.data_a", 32'(sink_data_a), 0);
        check_eq("rst.data_b", 32'(sink_data_b), 0);

        // Basic window of 4, strobe two edges after the 4th sample
        do_reset(4);
        add(1, 10, 1, 5,   0, 0, 0, 0, 0);
        add(1, 50, 1, 5,   0, 0, 0, 0, 0);
        add(1, 20, 1, 900, 0, 0, 0, 0, 0);
        add(1, 30, 1, 5,   0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(50, 900);
        add_idle(0);
        run_tab("win4");
        check_eq("win4.count", 32'(column_count), 1);

        // Channel A waits for B and keeps folding samples
        do_reset(2);
        add(1, 7,   0, 0, 0, 0, 0, 0, 0);
        add(1, 9,   0, 0, 0, 0, 0, 0, 0);
        add_idle(0);
        add(1, 100, 0, 0, 0, 0, 0, 0, 0);
        add_idle(0);
        add(0, 0,   1, 3, 0, 0, 0, 0, 0);
        add(0, 0,   1, 4, 0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(100, 4);
        add_idle(0);
        run_tab("wait");
        check_eq("wait.count", 32'(column_count), 1);

        // window_len = 0 acts as 1; continuous valid, strobes alternate
        do_reset(0);
        add(1, 10, 1, 1,   0, 0, 0, 0, 0);
        add(1, 4,  1, 100, 0, 0, 0, 0, 0);
        add(1, 20, 1, 2,   0, 0, 0, 0, 0);
        t_ev[t_n-1] = 1'b1; t_ea[t_n-1] = 10; t_eb[t_n-1] = 100;
        add(1, 6,  1, 200, 0, 0, 0, 0, 0);
        add(1, 30, 1, 3,   0, 1, 20, 200, 0);
        add(1, 2,  1, 300, 0, 0, 0, 0, 0);
        add(1, 40, 1, 4,   0, 1, 30, 300, 0);
        add(1, 1,  1, 400, 0, 0, 0, 0, 0);
        add_emit(40, 400);
        add_idle(0);
        run_tab("len0");
        check_eq("len0.count", 32'(column_count), 4);

        // Freeze over three windows, then a normal emit
        do_reset(1);
        add(1, 7,  1, 8,  1, 0, 0, 0, 0);
        add_idle(1);
        add(0, 0,  0, 0,  1, 0, 0, 0, 1);
        add(1, 9,  1, 10, 1, 0, 0, 0, 0);
        add_idle(1);
        add(0, 0,  0, 0,  1, 0, 0, 0, 1);
        add(1, 11, 1, 12, 1, 0, 0, 0, 0);
        add_idle(1);
        add(0, 0,  0, 0,  1, 0, 0, 0, 1);
        run_tab("frz");
        check_eq("frz.count_held", 32'(column_count), 0);
        add(1, 13, 1, 14, 0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(13, 14);
        add_idle(0);
        run_tab("unfrz");
        check_eq("unfrz.count", 32'(column_count), 1);

        // Reset in the middle of a window
        do_reset(4);
        add(1, 100, 1, 100, 0, 0, 0, 0, 0);
        add(1, 200, 1, 200, 0, 0, 0, 0, 0);
        add(1, 300, 1, 300, 0, 0, 0, 0, 0);
        add(1, 400, 1, 400, 0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(400, 400);
        add(1, 3000, 1, 3000, 0, 0, 0, 0, 0);
        add(1, 3001, 0, 0,    0, 0, 0, 0, 0);
        add(1, 3002, 0, 0,    0, 0, 0, 0, 0);
        run_tab("pre");
        check_eq("pre.count", 32'(column_count), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("midrst.valid_a", 32'(sink_valid_a), 0);
        check_eq("midrst.count", 32'(column_count), 0);
        check_eq("midrst.dropped", 32'(column_dropped), 0);
        add(1, 1, 1, 5, 0, 0, 0, 0, 0);
        add(1, 2, 1, 6, 0, 0, 0, 0, 0);
        add(1, 3, 1, 7, 0, 0, 0, 0, 0);
        add(1, 4, 1, 8, 0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(4, 8);
        add_idle(0);
        run_tab("post");
        check_eq("post.count", 32'(column_count), 1);

        // Peak decay sequence (plain peaks when decay is not built in)
        do_reset(1);
        add(1, 200, 1, 50, 0, 0, 0, 0, 0);
        add_idle(0);
`ifdef PEAK_DECAY_EN
        add_emit(200, 50);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(184, 34);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(168, 18);
        add(1, 190, 1, 0, 0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(190, 2);
`else
        add_emit(200, 50);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(0, 0);
        add(1, 190, 1, 0, 0, 0, 0, 0, 0);
        add_idle(0);
        add_emit(190, 0);
`endif
        run_tab("decay");
        check_eq("decay.count", 32'(column_count), 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
